cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
- Run/step/halt sequencer for the single-cycle RISC-V datapath on the FPGA board.
- Replaces the free-running divided CPU clock and ad-hoc ROM address counter with a board-clock-domain controller.
- Owns the PC (ROM word address), emits a one-cycle execute strobe `cpu_en_o` that gates RF/DM writes and PC update, and supports breakpoint and single-step from a push button.

Parameters:
- ADDR_W, 6, PC/ROM word-address width.
- LAST_ADDR, 15, last valid instruction word address.
- WRAP, 0, 1: PC wraps to 0 after LAST_ADDR; 0: halt after executing LAST_ADDR.
- DIV_FAST, 2**25, board clocks per execute strobe when slow_i=0.
- DIV_SLOW, 2**28, board clocks per execute strobe when slow_i=1.
- DEB_CYC, 1000000, board clocks the synchronised button must be stable to register.

Ports:
- clk  in  1  board clock; all logic on posedge.
- rstn  in  1  asynchronous active-low reset.
- run_i  in  1  level switch; rising edge enters RUN, 0 forces HALT.
- slow_i  in  1  selects DIV_SLOW vs DIV_FAST.
- step_btn_i  in  1  raw push button, asynchronous, bouncy.
- bp_en_i  in  1  breakpoint enable.
- bp_addr_i  in  ADDR_W  breakpoint word address.
- pc_sel_i  in  2  next-PC select: 0 = pc+1, 1 = branch taken, 2 = jump, 3 = treated as 0.
- target_i  in  ADDR_W  branch/jump target word address (from datapath, combinational on pc_o).
- pc_o  out  ADDR_W  current instruction word address.
- cpu_en_o  out  1  one-cycle execute/commit strobe.
- state_o  out  2  0 = IDLE, 1 = RUN, 2 = HALT, 3 = DONE.
- retired_o  out  16  count of cpu_en_o pulses, saturates at 16'hFFFF.

Behaviour:
- Reset (async, rstn=0): pc_o=0, cpu_en_o=0, state=IDLE, retired_o=0, tick counter=0, debounce state cleared, run edge detector primed with 0.
- Tick counter:
  - Counts in RUN only; cleared on every state change and on any slow_i change.
  - tick asserts when count == DIV-1; count then returns to 0.
  - Width is ceil(log2(DIV_SLOW)).
- Step input path:
  - step_btn_i passes through a 2-flop synchroniser, then a debouncer.
  - The debounced level changes only after DEB_CYC consecutive equal samples.
  - A step event is the 0->1 edge of the debounced level, one clock wide.
- cpu_en_o is registered and is never high on two consecutive cycles. On the cycle it is high:
  - pc_o updates: sel 1/2 -> target_i; else pc+1.
  - pc+1 at pc==LAST_ADDR gives 0 if WRAP=1; if WRAP=0, pc stays and state -> DONE.
  - retired_o increments (saturating).
- IDLE: run_i rising edge -> RUN. A step event issues one cpu_en_o and stays IDLE.
- RUN:
  - run_i=0 -> HALT; this has priority over a same-cycle tick, so no strobe is issued.
  - On tick, if bp_en_i and pc_o==bp_addr_i and not skip_bp: -> HALT, no strobe, PC unchanged.
  - Otherwise, on tick, issue cpu_en_o.
  - skip_bp is set on entry to RUN and cleared after the first strobe, so resuming at a breakpoint executes it.
- HALT:
  - A step event issues one cpu_en_o; no breakpoint check applies.
  - run_i rising edge -> RUN.
  - Step events during RUN are ignored.
- DONE: cpu_en_o stays 0. Leaving DONE requires reset; step and run are ignored.
- The run_i edge detector samples run_i through a 2-flop synchroniser.
- Reset mid-strobe: the strobe is dropped immediately (async), and pc_o returns to 0.

Test Plan:
(DIV_FAST=4, DIV_SLOW=8, DEB_CYC=3, LAST_ADDR=5, WRAP=0)
1. Reset, then run_i 0->1, pc_sel_i=0 -> cpu_en_o every 4 clocks; pc_o 0,1,2,3,4,5; after strobe at pc 5, state_o=3 and retired_o=6 with no further strobes.
2. RUN with slow_i=1 -> strobe spacing 8 clocks; toggle slow_i mid-count -> counter restarts, next strobe exactly 8 clocks after toggle.
3. bp_en_i=1, bp_addr_i=3 -> state_o=2 with pc_o=3, retired_o=3; re-raise run_i -> instruction at 3 executes, run continues to DONE.
4. HALT, button bounces 1-0-1 for 2 clocks then held 1 -> exactly one strobe, pc_o +1; held button produces no repeat.
5. RUN, pc_sel_i=2, target_i=1 at pc 4 -> pc_o becomes 1; pc_sel_i=3 -> treated as +1.
6. Assert rstn=0 on the cycle cpu_en_o is high -> cpu_en_o=0, pc_o=0, retired_o=0, state_o=0 immediately.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer for the single-cycle RISC-V datapath.
// Owns the PC and issues a one-cycle execute strobe in the board clock domain.
module cpu_run_ctrl #(
   parameter int unsigned ADDR_W    = 6,
   parameter int unsigned LAST_ADDR = 15,
   parameter bit          WRAP      = 1'b0,
   parameter int unsigned DIV_FAST  = 2**25,
   parameter int unsigned DIV_SLOW  = 2**28,
   parameter int unsigned DEB_CYC   = 1000000
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              run_i,
   input  logic              slow_i,
   input  logic              step_btn_i,
   input  logic              bp_en_i,
   input  logic [ADDR_W-1:0] bp_addr_i,
   input  logic [1:0]        pc_sel_i,
   input  logic [ADDR_W-1:0] target_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic              cpu_en_o,
   output logic [1:0]        state_o,
   output logic [15:0]       retired_o
);

   localparam int unsigned CNT_W = (DIV_SLOW > 1) ? $clog2(DIV_SLOW) : 1;
   localparam int unsigned DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic                en_nxt;
   logic                skip_bp;
   logic                skip_nxt;

   logic                run_s1;
   logic                run_s2;
   logic                run_q;
   logic                run_rise;
   logic                btn_s1;
   logic                btn_s2;

   logic                deb_lvl;
   logic                deb_q;
   logic [DEB_W-1:0]    deb_cnt;
   logic                step_evt;

   logic                slow_q;
   logic                slow_chg;
   logic [CNT_W-1:0]    tick_cnt;
   logic [CNT_W-1:0]    div_m1;
   logic                tick;

   logic [ADDR_W-1:0]   pc_nxt;
   logic                last_stop;

   // Two-flop synchronisers for the run switch and step button
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         run_s1 <= 1'b0;
         run_s2 <= 1'b0;
         run_q  <= 1'b0;
         btn_s1 <= 1'b0;
         btn_s2 <= 1'b0;
      end else begin
         run_s1 <= run_i;
         run_s2 <= run_s1;
         run_q  <= run_s2;
         btn_s1 <= step_btn_i;
         btn_s2 <= btn_s1;
      end
   end

   assign run_rise = run_s2 & ~run_q;

   // Debounced level flips only after DEB_CYC consecutive differing samples
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         deb_lvl <= 1'b0;
         deb_q   <= 1'b0;
         deb_cnt <= '0;
      end else begin
         deb_q <= deb_lvl;
         if (btn_s2 == deb_lvl) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_W'(DEB_CYC - 1)) begin
            deb_lvl <= btn_s2;
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
         end
      end
   end

   assign step_evt = deb_lvl & ~deb_q;

   // Execute-rate divider, restarted on any state or speed change
   assign div_m1   = slow_i ? CNT_W'(DIV_SLOW - 1) : CNT_W'(DIV_FAST - 1);
   assign slow_chg = slow_i ^ slow_q;
   assign tick     = (state == S_RUN) && !slow_chg && (tick_cnt == div_m1);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         slow_q   <= 1'b0;
         tick_cnt <= '0;
      end else begin
         slow_q <= slow_i;
         if ((state_nxt != state) || (state != S_RUN) || slow_chg || tick) begin
            tick_cnt <= '0;
         end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
         end
      end
   end

   // Next PC for the instruction committing under the current strobe
   always_comb begin
      pc_nxt    = pc_o + ADDR_W'(1);
      last_stop = 1'b0;
      if ((pc_sel_i == 2'd1) || (pc_sel_i == 2'd2)) begin
         pc_nxt = target_i;
      end else if (pc_o == ADDR_W'(LAST_ADDR)) begin
         if (WRAP) begin
            pc_nxt = '0;
         end else begin
            pc_nxt    = pc_o;
            last_stop = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Sequencer; the !cpu_en_o guards keep strobes at least one cycle apart
   always_comb begin
      state_nxt = state;
      en_nxt    = 1'b0;
      skip_nxt  = skip_bp;
      if (cpu_en_o) begin
         skip_nxt = 1'b0;
      end
      case (state)
         S_IDLE, S_HALT: begin
            if (run_rise) begin
               state_nxt = S_RUN;
               skip_nxt  = 1'b1;
            end else if (step_evt && !cpu_en_o) begin
               en_nxt = 1'b1;
            end
         end
         S_RUN: begin
            if (!run_s2) begin
               state_nxt = S_HALT;
            end else if (tick && !cpu_en_o) begin
               if (bp_en_i && (pc_o == bp_addr_i) && !skip_bp) begin
                  state_nxt = S_HALT;
               end else begin
                  en_nxt = 1'b1;
               end
            end
         end
         default: begin
            state_nxt = S_DONE;
         end
      endcase
      if (cpu_en_o && last_stop) begin
         state_nxt = S_DONE;
      end
   end

   // Strobe, PC and retire counter
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cpu_en_o  <= 1'b0;
         skip_bp   <= 1'b0;
         pc_o      <= '0;
         retired_o <= '0;
      end else begin
         cpu_en_o <= en_nxt;
         skip_bp  <= skip_nxt;
         if (cpu_en_o) begin
            pc_o <= pc_nxt;
            if (retired_o != 16'hFFFF) begin
               retired_o <= retired_o + 16'd1;
            end
         end
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with short dividers and debounce.
module tb_cpu_run_ctrl;

   logic       clk;
   logic       rstn;
   logic       run_i;
   logic       slow_i;
   logic       step_btn_i;
   logic       bp_en_i;
   logic [5:0] bp_addr_i;
   logic [1:0] pc_sel_i;
   logic [5:0] target_i;
   logic [5:0] pc_o;
   logic       cpu_en_o;
   logic [1:0] state_o;
   logic [15:0] retired_o;

   int         n_checks = 0;
   int         n_pass   = 0;
   int         cyc      = 0;
   logic [1:0] base_sel = 2'd0;
   logic [1:0] jump_sel = 2'd0;
   bit         prev_en  = 1'b0;

   cpu_run_ctrl #(
      .ADDR_W    (6),
      .LAST_ADDR (5),
      .WRAP      (1'b0),
      .DIV_FAST  (4),
      .DIV_SLOW  (8),
      .DEB_CYC   (3)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .run_i      (run_i),
      .slow_i     (slow_i),
      .step_btn_i (step_btn_i),
      .bp_en_i    (bp_en_i),
      .bp_addr_i  (bp_addr_i),
      .pc_sel_i   (pc_sel_i),
      .target_i   (target_i),
      .pc_o       (pc_o),
      .cpu_en_o   (cpu_en_o),
      .state_o    (state_o),
      .retired_o  (retired_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Datapath stand-in: next-PC select is combinational on pc_o
   always_comb begin
      target_i = 6'd1;
      pc_sel_i = base_sel;
      if ((pc_o == 6'd4) && (jump_sel != 2'd0)) pc_sel_i = jump_sel;
   end

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   always @(negedge clk) begin
      if (cpu_en_o) check("no_back_to_back", longint'(prev_en), 0);
      prev_en = cpu_en_o;
   end

   task automatic wait_strobe(input int max_cyc, output bit found, output int at, output logic [5:0] p);
      found = 1'b0;
      at    = -1;
      p     = '0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (cpu_en_o) begin
            found = 1'b1;
            at    = cyc;
            p     = pc_o;
            return;
         end
      end
   endtask

   task automatic count_strobes(input int n_cyc, output int n);
      n = 0;
      for (int i = 0; i < n_cyc; i++) begin
         @(negedge clk);
         if (cpu_en_o) n++;
      end
   endtask

   task automatic do_reset();
      rstn       = 1'b0;
      run_i      = 1'b0;
      slow_i     = 1'b0;
      step_btn_i = 1'b0;
      bp_en_i    = 1'b0;
      bp_addr_i  = 6'd0;
      base_sel   = 2'd0;
      jump_sel   = 2'd0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      bit         f;
      int         t_prev;
      int         t_now;
      int         n;
      int         njump;
      logic [5:0] p;
      int         exp_pc [14] = '{0, 1, 2, 3, 4, 1, 2, 3, 4, 1, 2, 3, 4, 5};

      // Reset values and quiet IDLE
      rstn = 1'b0;
      run_i = 1'b0; slow_i = 1'b0; step_btn_i = 1'b0;
      bp_en_i = 1'b0; bp_addr_i = 6'd0;
      repeat (2) @(negedge clk);
      check("rst_pc", pc_o, 0);
      check("rst_en", cpu_en_o, 0);
      check("rst_state", state_o, 0);
      check("rst_retired", retired_o, 0);
      rstn = 1'b1;
      count_strobes(10, n);
      check("idle_quiet", n, 0);
      check("idle_state", state_o, 0);

      // 1: free run at fast rate to DONE
      run_i  = 1'b1;
      t_prev = 0;
      for (int k = 0; k < 6; k++) begin
         wait_strobe(20, f, t_now, p);
         check("t1_found", f, 1);
         check("t1_pc", p, k);
         if (k > 0) check("t1_spacing", t_now - t_prev, 4);
         t_prev = t_now;
      end
      repeat (2) @(negedge clk);
      check("t1_state_done", state_o, 3);
      check("t1_retired", retired_o, 6);
      check("t1_pc_hold", pc_o, 5);
      count_strobes(20, n);
      check("t1_no_more", n, 0);
      run_i = 1'b0;
      repeat (5) @(negedge clk);
      run_i = 1'b1;
      step_btn_i = 1'b1;
      count_strobes(20, n);
      step_btn_i = 1'b0;
      check("t1_done_sticky_n", n, 0);
      check("t1_done_sticky_st", state_o, 3);

      // 2: slow rate and divider restart on speed change
      do_reset();
      slow_i = 1'b1;
      run_i  = 1'b1;
      wait_strobe(30, f, t_prev, p);
      check("t2_found0", f, 1);
      wait_strobe(30, f, t_now, p);
      check("t2_found1", f, 1);
      check("t2_slow_spacing", t_now - t_prev, 8);
      check("t2_pc1", p, 1);
      t_prev = t_now;
      slow_i = 1'b0;
      wait_strobe(30, f, t_now, p);
      check("t2_found2", f, 1);
      check("t2_fast_after_chg", t_now - t_prev, 5);
      check("t2_pc2", p, 2);
      repeat (2) @(negedge clk);
      t_prev = cyc;
      slow_i = 1'b1;
      wait_strobe(30, f, t_now, p);
      check("t2_found3", f, 1);
      check("t2_restart_slow", t_now - t_prev, 9);
      check("t2_pc3", p, 3);

      // 3: breakpoint halt and resume through it
      do_reset();
      bp_en_i   = 1'b1;
      bp_addr_i = 6'd3;
      run_i     = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_strobe(20, f, t_now, p);
         check("t3_found", f, 1);
         check("t3_pc", p, k);
      end
      wait_strobe(12, f, t_now, p);
      check("t3_bp_no_strobe", f, 0);
      check("t3_state_halt", state_o, 2);
      check("t3_pc_at_bp", pc_o, 3);
      check("t3_retired", retired_o, 3);
      run_i = 1'b0;
      repeat (5) @(negedge clk);
      check("t3_still_halt", state_o, 2);
      run_i = 1'b1;
      for (int k = 3; k < 6; k++) begin
         wait_strobe(20, f, t_now, p);
         check("t3_resume_found", f, 1);
         check("t3_resume_pc", p, k);
      end
      repeat (2) @(negedge clk);
      check("t3_state_done", state_o, 3);
      check("t3_retired_end", retired_o, 6);

      // 4: single step from IDLE and HALT with a bouncy button
      do_reset();
      bp_en_i   = 1'b1;
      bp_addr_i = 6'd2;
      step_btn_i = 1'b1;
      count_strobes(15, n);
      check("t4_idle_step_n", n, 1);
      check("t4_idle_pc", pc_o, 1);
      check("t4_idle_state", state_o, 0);
      step_btn_i = 1'b0;
      count_strobes(15, n);
      check("t4_release_n", n, 0);
      run_i = 1'b1;
      wait_strobe(20, f, t_now, p);
      check("t4_run_found", f, 1);
      check("t4_run_pc", p, 1);
      wait_strobe(12, f, t_now, p);
      check("t4_bp_no_strobe", f, 0);
      check("t4_halt", state_o, 2);
      check("t4_halt_pc", pc_o, 2);
      step_btn_i = 1'b1;
      @(negedge clk);
      step_btn_i = 1'b0;
      @(negedge clk);
      step_btn_i = 1'b1;
      count_strobes(25, n);
      check("t4_bounce_n", n, 1);
      check("t4_step_pc", pc_o, 3);
      check("t4_step_retired", retired_o, 3);
      check("t4_step_state", state_o, 2);
      step_btn_i = 1'b0;
      count_strobes(15, n);
      check("t4_release2_n", n, 0);

      // 5: jump, branch and select 3 as sequential
      do_reset();
      base_sel = 2'd3;
      jump_sel = 2'd2;
      njump    = 0;
      run_i    = 1'b1;
      for (int k = 0; k < 14; k++) begin
         wait_strobe(20, f, t_now, p);
         check("t5_found", f, 1);
         check("t5_pc", p, exp_pc[k]);
         if ((p == 6'd4) && (k < 13)) begin
            @(negedge clk);
            njump++;
            jump_sel = (njump == 1) ? 2'd1 : 2'd0;
         end
      end
      repeat (2) @(negedge clk);
      check("t5_state_done", state_o, 3);
      check("t5_retired", retired_o, 14);

      // 6: asynchronous reset in the middle of a strobe
      do_reset();
      run_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_strobe(20, f, t_now, p);
         check("t6_found", f, 1);
      end
      check("t6_pre_pc", pc_o, 2);
      #1 rstn = 1'b0;
      #1;
      check("t6_en", cpu_en_o, 0);
      check("t6_pc", pc_o, 0);
      check("t6_retired", retired_o, 0);
      check("t6_state", state_o, 0);
      run_i = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
